// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 16-bit combinational ALU between NREQ requesters.
// Optional ALU_OPCHECK_EN: opcodes 6/7 return an error response instead of an ALU result.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [DW-1:0]     rsp_data,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DW-1:0]     alu_out,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_v
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    logic [GW-1:0]   ptr_r;
    logic [GW-1:0]   grant_r;
    logic [GW-1:0]   winner_s;
    logic            found_s;
    logic [DW-1:0]   a_r;
    logic [DW-1:0]   b_r;
    logic [2:0]      op_r;
    logic [NREQ-1:0] rsp_valid_r;
    logic [GW-1:0]   ptr_next_s;
`ifdef ALU_OPCHECK_EN
    logic            err_r;
`endif

    // Round-robin search starting at ptr_r, wrapping modulo NREQ.
    always_comb begin
        winner_s = ptr_r;
        found_s  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            automatic int idx = int'(ptr_r) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found_s && req_valid[idx]) begin
                winner_s = GW'(idx);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Accept strobe is combinational, only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (!rst && (state_r == IDLE) && found_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Pointer moves past the requester just served.
    always_comb begin
        if (grant_r == GW'(NREQ - 1)) begin
            ptr_next_s = {GW{1'b0}};
        end else begin
            ptr_next_s = grant_r + GW'(1);
        end
    end

    // Arbitration FSM with latched operands and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= {GW{1'b0}};
            grant_r     <= {GW{1'b0}};
            a_r         <= {DW{1'b0}};
            b_r         <= {DW{1'b0}};
            op_r        <= 3'd0;
            rsp_valid_r <= {NREQ{1'b0}};
            rsp_data    <= {DW{1'b0}};
            rsp_flags   <= 4'd0;
`ifdef ALU_OPCHECK_EN
            err_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        a_r     <= req_a[winner_s*DW +: DW];
                        b_r     <= req_b[winner_s*DW +: DW];
                        op_r    <= req_op[winner_s*3 +: 3];
                        grant_r <= winner_s;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
`ifdef ALU_OPCHECK_EN
                    if (op_r[2:1] == 2'b11) begin
                        rsp_data  <= {DW{1'b0}};
                        rsp_flags <= 4'd0;
                        err_r     <= 1'b1;
                    end else begin
                        rsp_data  <= alu_out;
                        rsp_flags <= {alu_n, alu_z, alu_c, alu_v};
                        err_r     <= 1'b0;
                    end
`else
                    rsp_data  <= alu_out;
                    rsp_flags <= {alu_n, alu_z, alu_c, alu_v};
`endif
                    rsp_valid_r <= {{(NREQ-1){1'b0}}, 1'b1} << grant_r;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant_r]) begin
                        rsp_valid_r <= {NREQ{1'b0}};
                        ptr_r       <= ptr_next_s;
`ifdef ALU_OPCHECK_EN
                        err_r       <= 1'b0;
`endif
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= {NREQ{1'b0}};
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign alu_ctrl  = op_r;
`ifdef ALU_OPCHECK_EN
    assign rsp_err   = err_r;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 16-bit ALU attached.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic [3:0]        rsp_flags;
    logic              rsp_err;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [2:0]        alu_ctrl;
    logic [DW-1:0]     alu_out;
    logic              alu_z, alu_n, alu_c, alu_v;

    int vectors = 0;
    int miscompares = 0;

    alu_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v)
    );

    always #5 clk = ~clk;

    // Reference ALU; ops 6/7 return a recognisable pattern.
    always_comb begin
        logic [16:0] sum;
        sum   = 17'd0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_ctrl)
            3'd0: begin
                sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = sum[16];
                alu_v = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
            end
            3'd1: begin
                sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
                alu_c = sum[16];
                alu_v = (alu_a[15] != alu_b[15]) && (sum[15] != alu_a[15]);
            end
            3'd2:    sum = {1'b0, alu_a & alu_b};
            3'd3:    sum = {1'b0, alu_a | alu_b};
            3'd4:    sum = {1'b0, ~alu_b};
            3'd5:    sum = {1'b0, alu_a ^ alu_b};
            default: sum = {1'b0, 16'hDEAD};
        endcase
        alu_out = sum[15:0];
        alu_n   = sum[15];
        alu_z   = (sum[15:0] == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_op[i*3 +: 3]  = op;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_op = '0;
        tick(); tick();
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_rsp_flags", rsp_flags, 4'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_alu_a", alu_a, 16'h0000);

        // Add with signed overflow from requester 0
        set_req(0, 16'h7FFF, 16'h0001, 3'd0);
        req_valid = 2'b01;
        #1;
        check("rst_gates_ready", req_ready, 2'b00);
        rst = 1'b0;
        #1;
        check("add_req_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("add_exec_ready", req_ready, 2'b00);
        check("add_exec_alu_a", alu_a, 16'h7FFF);
        check("add_exec_ctrl", alu_ctrl, 3'd0);
        check("add_exec_no_rsp", rsp_valid, 2'b00);
        tick();
        check("add_rsp_valid", rsp_valid, 2'b01);
        check("add_rsp_data", rsp_data, 16'h8000);
        check("add_rsp_flags", rsp_flags, 4'b1001);
        rsp_ready = 2'b01;
        tick();
        check("add_rsp_drop", rsp_valid, 2'b00);

        // Subtract to zero from requester 1; wrong-line ready ignored
        rsp_ready = 2'b00;
        set_req(1, 16'h0005, 16'h0005, 3'd1);
        req_valid = 2'b10;
        #1;
        check("sub_req_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        check("sub_rsp_valid", rsp_valid, 2'b10);
        check("sub_rsp_data", rsp_data, 16'h0000);
        check("sub_rsp_flags", rsp_flags, 4'b0110);
        rsp_ready = 2'b01;
        tick();
        check("sub_wrong_ready", rsp_valid, 2'b10);
        rsp_ready = 2'b10;
        tick();
        check("sub_rsp_drop", rsp_valid, 2'b00);

        // Contention from the first cycle after reset
        rst = 1'b1;
        rsp_ready = 2'b11;
        set_req(0, 16'hF0F0, 16'h0FF0, 3'd5);
        set_req(1, 16'hFFFF, 16'h1234, 3'd2);
        req_valid = 2'b11;
        tick();
        rst = 1'b0;
        #1;
        check("cont_first_ready", req_ready, 2'b01);
        tick(); tick();
        check("cont_rsp0_valid", rsp_valid, 2'b01);
        check("cont_rsp0_data", rsp_data, 16'hFF00);
        check("cont_rsp0_flags", rsp_flags, 4'b1000);
        tick();
        check("cont_idle_drop", rsp_valid, 2'b00);
        check("cont_second_ready", req_ready, 2'b10);
        tick(); tick();
        check("cont_rsp1_valid", rsp_valid, 2'b10);
        check("cont_rsp1_data", rsp_data, 16'h1234);
        check("cont_rsp1_flags", rsp_flags, 4'b0000);
        tick();
        check("cont_third_ready", req_ready, 2'b01);
        tick(); tick();
        check("cont_rsp2_valid", rsp_valid, 2'b01);
        tick();
        check("cont_fourth_ready", req_ready, 2'b10);
        tick(); tick();
        check("cont_rsp3_valid", rsp_valid, 2'b10);

        // Backpressure on requester 0 while requester 1 stays valid
        tick();
        check("bp_first_ready", req_ready, 2'b01);
        rsp_ready = 2'b00;
        tick(); tick();
        check("bp_rsp_valid", rsp_valid, 2'b01);
        set_req(0, 16'h0000, 16'h0000, 3'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", rsp_valid, 2'b01);
            check("bp_hold_data", rsp_data, 16'hFF00);
            check("bp_hold_flags", rsp_flags, 4'b1000);
            check("bp_no_ready", req_ready, 2'b00);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("bp_release_drop", rsp_valid, 2'b00);
        check("bp_release_ready", req_ready, 2'b10);
        tick();
        check("bp_exec_ready", req_ready, 2'b00);
        check("bp_exec_ctrl", alu_ctrl, 3'd2);

        // Asynchronous reset in EXEC drops the operation
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", rsp_valid, 2'b00);
        check("arst_rsp_data", rsp_data, 16'h0000);
        check("arst_alu_a", alu_a, 16'h0000);
        check("arst_alu_ctrl", alu_ctrl, 3'd0);
        check("arst_req_ready", req_ready, 2'b00);
        tick();
        set_req(0, 16'h0001, 16'h0001, 3'd0);
        req_valid = 2'b11;
        rst = 1'b0;
        #1;
        check("arst_ptr0_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        check("arst_add_valid", rsp_valid, 2'b01);
        check("arst_add_data", rsp_data, 16'h0002);
        check("arst_add_flags", rsp_flags, 4'b0000);
        rsp_ready = 2'b01;
        tick();

        // Opcode 6 from requester 0
        rsp_ready = 2'b00;
        set_req(0, 16'h1234, 16'h5678, 3'd6);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        check("op6_rsp_valid", rsp_valid, 2'b01);
`ifdef ALU_OPCHECK_EN
        check("op6_rsp_err", rsp_err, 1'b1);
        check("op6_rsp_data", rsp_data, 16'h0000);
        check("op6_rsp_flags", rsp_flags, 4'b0000);
`else
        check("op6_rsp_err", rsp_err, 1'b0);
        check("op6_rsp_data", rsp_data, 16'hDEAD);
        check("op6_rsp_flags", rsp_flags, 4'b1000);
`endif
        rsp_ready = 2'b01;
        tick();
        check("op6_err_clear", rsp_err, 1'b0);
        rsp_ready = 2'b00;
        set_req(0, 16'h0002, 16'h0003, 3'd0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        check("post_add_valid", rsp_valid, 2'b01);
        check("post_add_err", rsp_err, 1'b0);
        check("post_add_data", rsp_data, 16'h0005);
        rsp_ready = 2'b01;
        tick();
        check("post_add_drop", rsp_valid, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
